// File: rtl/instr_cache_if.sv
// rtl/instr_cache_if.sv - fetch-side and main-memory-side signals of the instruction cache
interface instr_cache_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              req;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_out;
    logic              stall_out;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_data_valid;

    modport slave (
        input  req, addr_in, mem_data_in, mem_data_valid,
        output data_out, stall_out, mem_en, mem_addr
    );

    modport master (
        output req, addr_in, mem_data_in, mem_data_valid,
        input  data_out, stall_out, mem_en, mem_addr
    );
endinterface

// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped read-only instruction cache with line refill FSM
// Hits return data combinationally; misses stall and refill the whole line one word per cycle.
module instr_cache #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 3,
    parameter int ADDR_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    instr_cache_if.slave  bus
);
    localparam int TAG_BITS = ADDR_W - INDEX_BITS - OFFSET_BITS - 1;
    localparam int LINES    = 2 ** INDEX_BITS;
    localparam int WORDS    = 2 ** OFFSET_BITS;

    localparam logic [OFFSET_BITS:0]   ISS_ONE   = 1;
    localparam logic [OFFSET_BITS:0]   ISS_LIMIT = WORDS;
    localparam logic [OFFSET_BITS-1:0] RCV_ONE   = 1;
    localparam logic [OFFSET_BITS-1:0] RCV_LAST  = OFFSET_BITS'(WORDS - 1);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t                  state_q, state_d;
    logic [TAG_BITS-1:0]     miss_tag_q, miss_tag_d;
    logic [INDEX_BITS-1:0]   miss_idx_q, miss_idx_d;
    logic [OFFSET_BITS:0]    iss_cnt_q, iss_cnt_d;
    logic [OFFSET_BITS-1:0]  rcv_cnt_q, rcv_cnt_d;
    logic                    mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;

    logic                    valid_q [LINES];
    logic [TAG_BITS-1:0]     tag_arr_q [LINES];
    logic [15:0]             data_arr_q [LINES][WORDS];

    logic [TAG_BITS-1:0]     lk_tag;
    logic [INDEX_BITS-1:0]   lk_idx;
    logic [OFFSET_BITS-1:0]  lk_word;
    logic                    hit;
    logic                    data_we;
    logic                    install;
    logic                    invalidate;
    logic [OFFSET_BITS:0]    iss_next;
    logic                    unused_addr_lsb;

    assign lk_tag          = bus.addr_in[ADDR_W-1 -: TAG_BITS];
    assign lk_idx          = bus.addr_in[OFFSET_BITS+1 +: INDEX_BITS];
    assign lk_word         = bus.addr_in[1 +: OFFSET_BITS];
    assign unused_addr_lsb = bus.addr_in[0];

    assign hit = bus.req && valid_q[lk_idx] && (tag_arr_q[lk_idx] == lk_tag)
                 && (state_q == S_IDLE);

    assign bus.data_out  = data_arr_q[lk_idx][lk_word];
    assign bus.stall_out = (state_q != S_IDLE) || (bus.req && !hit);
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_addr  = mem_addr_q;

    always_comb begin
        state_d    = state_q;
        miss_tag_d = miss_tag_q;
        miss_idx_d = miss_idx_q;
        iss_cnt_d  = iss_cnt_q;
        rcv_cnt_d  = rcv_cnt_q;
        mem_en_d   = mem_en_q;
        mem_addr_d = mem_addr_q;
        data_we    = 1'b0;
        install    = 1'b0;
        invalidate = 1'b0;
        iss_next   = iss_cnt_q + ISS_ONE;
        case (state_q)
            S_IDLE: begin
                if (bus.req && !hit) begin
                    // The victim line goes invalid now since its words are about to be overwritten.
                    state_d    = S_FILL;
                    miss_tag_d = lk_tag;
                    miss_idx_d = lk_idx;
                    iss_cnt_d  = '0;
                    rcv_cnt_d  = '0;
                    invalidate = 1'b1;
                    mem_en_d   = 1'b1;
                    mem_addr_d = {lk_tag, lk_idx, {OFFSET_BITS{1'b0}}, 1'b0};
                end
            end
            S_FILL: begin
                if (mem_en_q) begin
                    iss_cnt_d = iss_next;
                    if (iss_next < ISS_LIMIT) begin
                        mem_addr_d = {miss_tag_q, miss_idx_q, iss_next[OFFSET_BITS-1:0], 1'b0};
                    end else begin
                        mem_en_d   = 1'b0;
                        mem_addr_d = '0;
                    end
                end
                if (bus.mem_data_valid) begin
                    data_we   = 1'b1;
                    rcv_cnt_d = rcv_cnt_q + RCV_ONE;
                    if (rcv_cnt_q == RCV_LAST) begin
                        install    = 1'b1;
                        state_d    = S_IDLE;
                        mem_en_d   = 1'b0;
                        mem_addr_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            iss_cnt_q  <= '0;
            rcv_cnt_q  <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                valid_q[i]   <= 1'b0;
                tag_arr_q[i] <= '0;
                for (int j = 0; j < WORDS; j++) begin
                    data_arr_q[i][j] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
            iss_cnt_q  <= iss_cnt_d;
            rcv_cnt_q  <= rcv_cnt_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            if (invalidate) begin
                valid_q[lk_idx] <= 1'b0;
            end
            if (data_we) begin
                data_arr_q[miss_idx_q][rcv_cnt_q] <= bus.mem_data_in;
            end
            // Installed line becomes visible to lookups from the following cycle.
            if (install) begin
                tag_arr_q[miss_idx_q] <= miss_tag_q;
                valid_q[miss_idx_q]   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_cache.sv
// tb/tb_instr_cache.sv - scoreboard bench for instr_cache with a latency-programmable memory model
module tb_instr_cache;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_cache_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    instr_cache dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          due;
        logic [15:0] d;
    } resp_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          lat      = 4;
    int          stray_n  = 0;
    bit          stray_next = 1'b0;
    int          last_start = 0;
    logic [15:0] exp_q[$];
    resp_t       pend[$];
    logic [15:0] log_a[$];
    int          log_c[$];
    bit          mv[64];
    logic [5:0]  mt[64];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a + 16'h1000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Memory model: request seen at cycle t returns its word in cycle t+lat.
    always @(negedge clk) begin
        if (bus.mem_en === 1'b1) begin
            log_a.push_back(bus.mem_addr);
            log_c.push_back(cyc);
            pend.push_back('{cyc + lat, mem_word(bus.mem_addr)});
        end else if (!rst) begin
            chk("mem_addr_idle", bus.mem_addr, 32'h0);
        end
    end

    initial begin
        bus.mem_data_valid = 1'b0;
        bus.mem_data_in    = '0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                bus.mem_data_valid = 1'b1;
                bus.mem_data_in    = pend[0].d;
                void'(pend.pop_front());
                stray_next = (pend.size() == 0);
            end else if (stray_next && stray_n > 0) begin
                bus.mem_data_valid = 1'b1;
                bus.mem_data_in    = 16'hDEAD;
                stray_n    = stray_n - 1;
                stray_next = 1'b0;
            end else begin
                bus.mem_data_valid = 1'b0;
                bus.mem_data_in    = '0;
                stray_next = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every presented instruction pops one expected word.
    always @(negedge clk) begin
        if (!rst && bus.req === 1'b1 && bus.stall_out === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_hit", {16'h0, bus.addr_in}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_data_out", bus.data_out, exp_q.pop_front());
            end
        end
    end

    task automatic clear_log();
        log_a.delete();
        log_c.delete();
    endtask

    // Present one fetch (entered just after a rising edge) and count its stall cycles.
    task automatic fetch(input logic [15:0] a, input int exp_stall, input string name);
        int n;
        bus.req     = 1'b1;
        bus.addr_in = a;
        exp_q.push_back(mem_word(a));
        n = 0;
        @(negedge clk);
        last_start = cyc;
        while (bus.stall_out === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk(name, n, exp_stall);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_line_reqs(input string name, input logic [15:0] base);
        chk({name, "_nreq"}, log_a.size(), 8);
        for (int i = 0; i < 8 && i < log_a.size(); i++) begin
            chk($sformatf("%s_addr%0d", name, i), log_a[i], base + 16'(2 * i));
            chk($sformatf("%s_cyc%0d", name, i), log_c[i] - last_start, i + 1);
        end
    endtask

    task automatic model_fetch(input logic [15:0] a, input string name);
        logic [5:0] t;
        logic [5:0] ix;
        int         es;
        t  = a[15:10];
        ix = a[9:4];
        es = (mv[ix] && mt[ix] == t) ? 0 : 9 + lat;
        mv[ix] = 1'b1;
        mt[ix] = t;
        fetch(a, es, name);
    endtask

    initial begin
        int          s;
        int          n;
        logic [15:0] ra;
        int          lats[2];
        lats[0] = 1;
        lats[1] = 8;

        // Reset: stall_out follows req while the array is invalid.
        bus.req     = 1'b1;
        bus.addr_in = 16'h0040;
        @(negedge clk);
        chk("rst_stall_eq_req", bus.stall_out, 1);
        chk("rst_mem_en", bus.mem_en, 0);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall_idle", bus.stall_out, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        @(posedge clk);
        #1;

        // Cold miss at L=4, then the rest of the line back-to-back.
        lat = 4;
        clear_log();
        fetch(16'h0000, 13, "t1_stall");
        chk_line_reqs("t1", 16'h0000);
        clear_log();
        for (int i = 1; i < 8; i++) fetch(16'(2 * i), 0, $sformatf("t2_stall%0d", i));
        chk("t2_no_mem_req", log_a.size(), 0);

        // Conflict misses on line 0.
        fetch(16'h0400, 13, "t3_stall_tag1");
        clear_log();
        fetch(16'h0000, 13, "t3_stall_tag0");
        chk_line_reqs("t3", 16'h0000);

        // Address redirect mid-fill plus one stray valid after the 8th word.
        fetch(16'h0400, 13, "t5_pre");
        clear_log();
        bus.addr_in = 16'h0000;
        s = cyc;
        repeat (3) @(posedge clk);
        #1;
        bus.addr_in = 16'h0020;
        exp_q.push_back(mem_word(16'h0020));
        stray_n = 1;
        n = 0;
        @(negedge clk);
        while (bus.stall_out === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("t5_total_stall", cyc - s, 26);
        chk("t5_nreq", log_a.size(), 16);
        if (log_a.size() == 16) begin
            chk("t5_first_old", log_a[0], 16'h0000);
            chk("t5_last_old", log_a[7], 16'h000E);
            chk("t5_new_addr", log_a[8], 16'h0020);
            chk("t5_new_cyc", log_c[8] - s, 14);
        end
        chk("t5_stray_sent", stray_n, 0);
        @(posedge clk);
        #1;
        fetch(16'h0000, 0, "t5_line0_w0");
        fetch(16'h000E, 0, "t5_line0_w7");

        // Reset in cycle 5 of a refill.
        clear_log();
        bus.addr_in = 16'h0400;
        repeat (5) @(posedge clk);
        #1;
        rst     = 1'b1;
        bus.req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t4_mem_en", bus.mem_en, 0);
        chk("t4_stall", bus.stall_out, 0);
        chk("t4_reqs_before_rst", log_a.size(), 5);
        n = 0;
        while (pend.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("t4_drain", pend.size(), 0);
        @(posedge clk);
        #1;
        clear_log();
        fetch(16'h0000, 13, "t4_refill0");
        chk_line_reqs("t4", 16'h0000);
        fetch(16'h0006, 0, "t4_hit0");
        fetch(16'h0400, 13, "t4_refill1");

        // Latency sweep with random fetch streams against a tag model.
        rst     = 1'b1;
        bus.req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 64; k++) begin
            mv[k] = 1'b0;
            mt[k] = '0;
        end
        for (int li = 0; li < 2; li++) begin
            lat = lats[li];
            model_fetch(16'h0060 + 16'(li * 16'h0400), $sformatf("t6_L%0d_first", lat));
            for (int r = 0; r < 30; r++) begin
                ra = {6'($urandom_range(0, 2)), 6'($urandom_range(0, 3)),
                      3'($urandom_range(0, 7)), 1'b0};
                model_fetch(ra, $sformatf("t6_L%0d_r%0d_%h", lat, r, ra));
            end
        end

        bus.req = 1'b0;
        repeat (3) @(posedge clk);
        chk("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
